// File: rtl/puf_fu_issuer.sv
// rtl/puf_fu_issuer.sv - PUF challenge issuer: request FIFO, FU handshake, result capture, timeout
// Optional saturating completion/timeout counters are built when PUF_ISSUER_PERF_EN is defined.
module puf_fu_issuer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [XLEN-1:0]          req_challenge_i,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
  output logic                     fu_valid_o,
  input  logic                     fu_ready_i,
  output logic [XLEN-1:0]          fu_operand_o,
  output logic [TRANS_ID_BITS-1:0] fu_trans_id_o,
  input  logic                     fu_res_valid_i,
  input  logic [XLEN-1:0]          fu_res_i,
  input  logic [TRANS_ID_BITS-1:0] fu_res_id_i,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     wb_exception_o,
  output logic                     busy_o
`ifdef PUF_ISSUER_PERF_EN
  ,
  output logic [15:0]              perf_done_o,
  output logic [15:0]              perf_timeout_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WB
  } state_e;

  logic [XLEN-1:0]          chal_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] tid_q  [DEPTH];
  logic [AW:0]              wptr_q, rptr_q;
  state_e                   state_q;
  logic [TW-1:0]            timer_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [XLEN-1:0]          res_q;
  logic                     exc_q;

  logic empty, full, push, pop, res_match, timed_out, wb_fire;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push      = req_valid_i && !full && !flush_i;
  assign pop       = fu_valid_o && fu_ready_i;
  assign res_match = fu_res_valid_i && (fu_res_id_i == id_q);
  assign timed_out = (timer_q == TW'(TIMEOUT - 1));
  assign wb_fire   = (state_q == ST_WB) && !flush_i;

  assign req_ready_o    = !full;
  assign fu_valid_o     = (state_q == ST_IDLE) && !empty && !flush_i;
  assign fu_operand_o   = fu_valid_o ? chal_q[rptr_q[AW-1:0]] : '0;
  assign fu_trans_id_o  = fu_valid_o ? tid_q[rptr_q[AW-1:0]] : '0;
  assign wb_valid_o     = wb_fire;
  assign wb_result_o    = wb_fire ? res_q : '0;
  assign wb_trans_id_o  = wb_fire ? id_q : '0;
  assign wb_exception_o = wb_fire && exc_q;
  assign busy_o         = !empty || (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      chal_q[wptr_q[AW-1:0]] <= req_challenge_i;
      tid_q[wptr_q[AW-1:0]]  <= req_trans_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= ST_IDLE;
      timer_q <= '0;
      id_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            id_q    <= tid_q[rptr_q[AW-1:0]];
            timer_q <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer_q <= timer_q + TW'(1);
          // A matching result beats a timeout landing in the same cycle.
          if (res_match) begin
            res_q   <= fu_res_i;
            exc_q   <= 1'b0;
            state_q <= ST_WB;
          end else if (timed_out) begin
            res_q   <= '0;
            exc_q   <= 1'b1;
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PUF_ISSUER_PERF_EN
  logic [15:0] perf_done_q, perf_timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_done_q    <= '0;
      perf_timeout_q <= '0;
    end else if (wb_fire) begin
      if (exc_q) begin
        if (perf_timeout_q != 16'hFFFF) perf_timeout_q <= perf_timeout_q + 16'd1;
      end else begin
        if (perf_done_q != 16'hFFFF) perf_done_q <= perf_done_q + 16'd1;
      end
    end
  end

  assign perf_done_o    = perf_done_q;
  assign perf_timeout_o = perf_timeout_q;
`endif

endmodule
